// File: rtl/vxe_mem_hub_m_ds_pkg.sv
// Shared definitions for the mem hub master-side downstream distributor.
package vxe_mem_hub_m_ds_pkg;

  localparam int unsigned RSS_W            = 9;
  localparam int unsigned RSS_HAS_DATA_BIT = 8;
  localparam int unsigned RSD_W            = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STAT = 2'd2
  } state_t;

endpackage

// File: rtl/vxe_mem_hub_m_ds.sv
// Master-side downstream distributor: pops one response (status plus optional
// data beat) from a master port and steers it into the per-client FIFOs.
// Optional feature macro: VXE_MEM_HUB_M_DS_CID_CHECK_EN (out-of-range cid drop
// counter).
module vxe_mem_hub_m_ds
  import vxe_mem_hub_m_ds_pkg::*;
#(
  parameter int unsigned N_CLIENTS = 6,
  parameter int unsigned CID_W     = 3
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   i_rss_vld,
  input  logic [CID_W+RSS_W-1:0] i_rss,
  output logic                   o_rss_rd,
  input  logic                   i_rsd_vld,
  input  logic [RSD_W-1:0]       i_rsd,
  output logic                   o_rsd_rd,
  output logic [RSS_W-1:0]       o_c_rss,
  output logic [N_CLIENTS-1:0]   o_c_rss_wr,
  input  logic [N_CLIENTS-1:0]   i_c_rss_rdy,
  output logic [RSD_W-1:0]       o_c_rsd,
  output logic [N_CLIENTS-1:0]   o_c_rsd_wr,
  input  logic [N_CLIENTS-1:0]   i_c_rsd_rdy,
  output logic                   o_busy,
  output logic [7:0]             o_drop_cnt
);

  state_t                 state;
  state_t                 state_nxt;
  logic [CID_W-1:0]       cid_q;
  logic [RSS_W-1:0]       rss_q;
  logic [RSD_W-1:0]       rsd_q;
  logic                   s_done;
  logic                   d_done;
  logic                   has_data;
  logic                   cid_ok;
  logic [N_CLIENTS-1:0]   sel;
  logic                   rss_rd;
  logic                   rsd_rd;
  logic [N_CLIENTS-1:0]   rss_wr;
  logic [N_CLIENTS-1:0]   rsd_wr;
  logic                   stat_exit;

  assign has_data = rss_q[RSS_HAS_DATA_BIT];
  assign cid_ok   = 32'(cid_q) < N_CLIENTS;
  // One-hot client select; an out-of-range cid selects nobody.
  assign sel      = cid_ok ? (N_CLIENTS'(1) << cid_q) : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and pop/write strobes; all strobes are forced low while in reset.
  always_comb begin
    state_nxt = state;
    rss_rd    = 1'b0;
    rsd_rd    = 1'b0;
    rss_wr    = '0;
    rsd_wr    = '0;
    stat_exit = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_rss_vld) begin
          rss_rd    = 1'b1;
          state_nxt = i_rss[RSS_HAS_DATA_BIT] ? S_DATA : S_STAT;
        end
      end
      S_DATA: begin
        if (i_rsd_vld) begin
          rsd_rd    = 1'b1;
          state_nxt = S_STAT;
        end
      end
      S_STAT: begin
        if (!s_done)             rss_wr = sel & i_c_rss_rdy;
        if (has_data && !d_done) rsd_wr = sel & i_c_rsd_rdy;
        if (!cid_ok ||
            ((s_done || (|rss_wr)) && (!has_data || d_done || (|rsd_wr)))) begin
          stat_exit = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!nrst) begin
      rss_rd    = 1'b0;
      rsd_rd    = 1'b0;
      rss_wr    = '0;
      rsd_wr    = '0;
      stat_exit = 1'b0;
    end
  end

  // Hold registers and per-response write-done flags.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cid_q  <= '0;
      rss_q  <= '0;
      rsd_q  <= '0;
      s_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      if (rss_rd) begin
        cid_q <= i_rss[RSS_W +: CID_W];
        rss_q <= i_rss[RSS_W-1:0];
      end
      if (rsd_rd) rsd_q <= i_rsd;
      if (stat_exit) begin
        s_done <= 1'b0;
        d_done <= 1'b0;
      end else begin
        if (|rss_wr) s_done <= 1'b1;
        if (|rsd_wr) d_done <= 1'b1;
      end
    end
  end

`ifdef VXE_MEM_HUB_M_DS_CID_CHECK_EN
  logic [7:0] drop_cnt;

  // Saturating count of responses discarded for an out-of-range cid.
  always_ff @(posedge clk) begin
    if (!nrst)                                             drop_cnt <= 8'd0;
    else if (stat_exit && !cid_ok && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
  end

  assign o_drop_cnt = drop_cnt;
`else
  assign o_drop_cnt = 8'd0;
`endif

  assign o_rss_rd   = rss_rd;
  assign o_rsd_rd   = rsd_rd;
  assign o_c_rss_wr = rss_wr;
  assign o_c_rsd_wr = rsd_wr;
  assign o_c_rss    = rss_q;
  assign o_c_rsd    = rsd_q;
  assign o_busy     = (state != S_IDLE);

endmodule
